// File: rtl/wb_pkg.sv
// Shared types for the Wishbone pipelined-mode protocol monitor: violation
// indices, the sticky violation vector and a first-violation priority helper.
package wb_pkg;

    typedef enum logic [2:0] {
        V_STB_NO_CYC     = 3'd0,
        V_SPURIOUS       = 3'd1,
        V_ACK_AND_ERR    = 3'd2,
        V_STALL_UNSTABLE = 3'd3,
        V_OVERFLOW       = 3'd4,
        V_TIMEOUT        = 3'd5,
        V_ABANDON        = 3'd6
    } viol_idx_e;

    localparam int NumViol = 7;

    typedef logic [NumViol-1:0] viol_vec_t;

    // Lowest set index wins when several rules fire in the same cycle.
    function automatic viol_idx_e lowest_viol(viol_vec_t v);
        viol_idx_e idx;
        idx = V_STB_NO_CYC;
        for (int i = NumViol - 1; i >= 0; i--) begin
            if (v[i]) idx = viol_idx_e'(3'(i));
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Response-latency watchdog: counts consecutive cycles with work outstanding
// and no response, flagging the cycle in which the count reaches TimeoutCycles.
module wb_timeout_counter #(
    parameter int TimeoutCycles = 16,
    localparam int TW = $clog2(TimeoutCycles + 1)
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic active,
    input  logic resp,
    output logic hit
);

    localparam logic [TW-1:0] Limit = TW'(TimeoutCycles);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;
    logic          inc;

    assign inc = active & ~resp;

    always_comb begin
        cnt_d = '0;
        if (inc) cnt_d = (cnt_q == Limit) ? cnt_q : cnt_q + TW'(1);
    end

    // Fires on the increment that lands exactly on the limit, then saturates.
    assign hit = inc && (cnt_q == Limit - TW'(1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/wb_pipe_monitor.sv
// Passive Wishbone pipelined-mode protocol checker with sticky per-rule flags.
// Define WB_MONITOR_TIMEOUT_EN to build in the response-timeout rule.
module wb_pipe_monitor
    import wb_pkg::*;
#(
    parameter int DataWidth      = 32,
    parameter int AddrWidth      = 30,
    parameter int MaxOutstanding = 4,
    parameter int TimeoutCycles  = 16,
    localparam int SelWidth = DataWidth / 8,
    localparam int CntWidth = $clog2(MaxOutstanding + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 wb_cyc_o,
    input  logic                 wb_stb_o,
    input  logic                 wb_we_o,
    input  logic [AddrWidth-1:0] wb_addr_o,
    input  logic [DataWidth-1:0] wb_data_o,
    input  logic [SelWidth-1:0]  wb_sel_o,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i,
    input  logic                 wb_stall_i,
    input  logic [DataWidth-1:0] wb_data_i,
    output logic [CntWidth-1:0]  outstanding_o,
    output logic [6:0]           violation_o,
    output logic                 error_o,
    output logic [2:0]           first_code_o,
    output logic                 first_valid_o
);

    localparam logic [CntWidth-1:0] MaxOut = CntWidth'(MaxOutstanding);
    localparam int unused_timeout = TimeoutCycles;

    logic unused_data;
    assign unused_data = ^wb_data_i;

    // Handshake: a request is accepted when cyc&stb&!stall; a response is
    // ack|err; one cycle may carry both an acceptance and a response.
    logic accept, resp;
    assign accept = wb_cyc_o & wb_stb_o & ~wb_stall_i;
    assign resp   = wb_ack_i | wb_err_i;

    logic [CntWidth-1:0]  outstanding_q, outstanding_d;
    logic                 cyc_q, stalled_q, we_q;
    logic [AddrWidth-1:0] addr_q;
    logic [SelWidth-1:0]  sel_q;
    logic [DataWidth-1:0] data_q;
    viol_vec_t            viol_q, viol_now;
    logic                 error_q, first_valid_q;
    viol_idx_e            first_code_q;
    logic                 timeout_hit;
    logic                 payload_changed;

    always_comb begin
        outstanding_d = outstanding_q;
        if (!wb_cyc_o) begin
            outstanding_d = '0;
        end else if (accept && !resp && outstanding_q != MaxOut) begin
            outstanding_d = outstanding_q + CntWidth'(1);
        end else if (resp && !accept && outstanding_q != '0) begin
            outstanding_d = outstanding_q - CntWidth'(1);
        end
    end

`ifdef WB_MONITOR_TIMEOUT_EN
    wb_timeout_counter #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timeout (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .active (outstanding_q != '0),
        .resp   (resp),
        .hit    (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // Write data only matters while the held request is a write.
    assign payload_changed = (wb_addr_o != addr_q) || (wb_we_o != we_q) ||
                             (wb_sel_o != sel_q) || (wb_we_o && (wb_data_o != data_q));

    always_comb begin
        viol_now = '0;
        viol_now[V_STB_NO_CYC]     = wb_stb_o & ~wb_cyc_o;
        viol_now[V_SPURIOUS]       = resp & ((outstanding_q == '0) | ~wb_cyc_o);
        viol_now[V_ACK_AND_ERR]    = wb_ack_i & wb_err_i;
        viol_now[V_STALL_UNSTABLE] = stalled_q & (~wb_stb_o | (wb_cyc_o & payload_changed));
        viol_now[V_OVERFLOW]       = accept & (outstanding_q == MaxOut) & ~resp;
        viol_now[V_TIMEOUT]        = timeout_hit;
        viol_now[V_ABANDON]        = cyc_q & ~wb_cyc_o & (outstanding_q != '0);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            outstanding_q <= '0;
            cyc_q         <= 1'b0;
            stalled_q     <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            sel_q         <= '0;
            data_q        <= '0;
            viol_q        <= '0;
            error_q       <= 1'b0;
            first_valid_q <= 1'b0;
            first_code_q  <= V_STB_NO_CYC;
        end else begin
            outstanding_q <= outstanding_d;
            cyc_q         <= wb_cyc_o;
            stalled_q     <= wb_cyc_o & wb_stb_o & wb_stall_i;
            we_q          <= wb_we_o;
            addr_q        <= wb_addr_o;
            sel_q         <= wb_sel_o;
            data_q        <= wb_data_o;
            viol_q        <= viol_q | viol_now;
            error_q       <= |(viol_q | viol_now);
            if (!first_valid_q && |viol_now) begin
                first_valid_q <= 1'b1;
                first_code_q  <= lowest_viol(viol_now);
            end
        end
    end

    assign outstanding_o = outstanding_q;
    assign violation_o   = viol_q;
    assign error_o       = error_q;
    assign first_code_o  = first_code_q;
    assign first_valid_o = first_valid_q;

endmodule

// File: tb/tb_wb_pipe_monitor.sv
// Directed self-checking bench for wb_pipe_monitor: expected output snapshots
// are queued as each cycle is driven and compared after the clock edge.
module tb_wb_pipe_monitor;

    localparam int DW = 32;
    localparam int AW = 30;
    localparam int MO = 4;
    localparam int TO = 16;
    localparam int SW = DW / 8;
    localparam int CW = $clog2(MO + 1);
`ifdef WB_MONITOR_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic          clk_i, reset_i;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_data_o, wb_data_i;
    logic [SW-1:0] wb_sel_o;
    logic          wb_ack_i, wb_err_i, wb_stall_i;
    logic [CW-1:0] outstanding_o;
    logic [6:0]    violation_o;
    logic          error_o;
    logic [2:0]    first_code_o;
    logic          first_valid_o;

    wb_pipe_monitor #(
        .DataWidth(DW), .AddrWidth(AW), .MaxOutstanding(MO), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_sel_o(wb_sel_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_stall_i(wb_stall_i),
        .wb_data_i(wb_data_i),
        .outstanding_o(outstanding_o), .violation_o(violation_o), .error_o(error_o),
        .first_code_o(first_code_o), .first_valid_o(first_valid_o)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // scoreboard: {first_valid, first_code[2:0], error, violation[6:0], outstanding[2:0]}
    logic [14:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] out, input logic [6:0] viol,
                            input logic fv, input logic [2:0] fc);
        exp_q.push_back({fv, fc, |viol, viol, out});
    endtask

    task automatic compare_now(input string tag);
        logic [14:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".outstanding"}, 8'(outstanding_o), 8'(e[2:0]));
            check({tag, ".violation"},   8'(violation_o),   8'(e[9:3]));
            check({tag, ".error"},       8'(error_o),       8'(e[10]));
            check({tag, ".first_code"},  8'(first_code_o),  8'(e[13:11]));
            check({tag, ".first_valid"}, 8'(first_valid_o), 8'(e[14]));
        end
    endtask

    // driver tasks
    task automatic drive(input logic cyc, input logic stb, input logic we, input logic stall,
                         input logic ack, input logic err, input logic [AW-1:0] addr);
        wb_cyc_o   = cyc;
        wb_stb_o   = stb;
        wb_we_o    = we;
        wb_stall_i = stall;
        wb_ack_i   = ack;
        wb_err_i   = err;
        wb_addr_o  = addr;
        wb_data_o  = {2'b00, addr} ^ 32'h5a5a_0000;
        wb_sel_o   = '1;
        wb_data_i  = 32'(addr) ^ 32'hdead_0000;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic step(input string tag, input logic [2:0] out, input logic [6:0] viol,
                        input logic fv, input logic [2:0] fc);
        push_exp(out, viol, fv, fc);
        @(posedge clk_i);
        #1;
        compare_now(tag);
    endtask

    // Asserted between edges so the clear must come from the asynchronous path.
    task automatic pulse_reset(input string tag);
        reset_i = 1'b1;
        #2;
        push_exp(3'd0, 7'd0, 1'b0, 3'd0);
        compare_now(tag);
        reset_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] vv;
        reset_i = 1'b1;
        idle();
        @(posedge clk_i);
        #1;
        push_exp(3'd0, 7'd0, 1'b0, 3'd0);
        compare_now("reset");
        reset_i = 1'b0;

        // clean three-beat burst
        drive(1, 1, 0, 0, 0, 0, 'h100); step("burst_a0", 1, 7'd0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 'h101); step("burst_a1", 2, 7'd0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 'h102); step("burst_a2", 3, 7'd0, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 'h0);   step("burst_k0", 2, 7'd0, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 'h0);   step("burst_k1", 1, 7'd0, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 'h0);   step("burst_k2", 0, 7'd0, 0, 0);
        idle();                         step("burst_idle", 0, 7'd0, 0, 0);

        // spurious ack with nothing outstanding, then clean traffic
        drive(1, 0, 0, 0, 1, 0, 'h0);   step("spur", 0, 7'b0000010, 1, 1);
        drive(1, 1, 1, 0, 0, 0, 'h200); step("spur_wr", 1, 7'b0000010, 1, 1);
        drive(1, 0, 0, 0, 1, 0, 'h0);   step("spur_ack", 0, 7'b0000010, 1, 1);
        idle();                         step("spur_idle", 0, 7'b0000010, 1, 1);

        // address changes under stall, later ack and err together
        pulse_reset("rst_before_stall");
        drive(1, 1, 0, 1, 0, 0, 'h10);  step("stall_hold", 0, 7'd0, 0, 0);
        drive(1, 1, 0, 1, 0, 0, 'h14);  step("stall_change", 0, 7'b0001000, 1, 3);
        drive(1, 1, 0, 0, 0, 0, 'h14);  step("stall_accept", 1, 7'b0001000, 1, 3);
        drive(1, 0, 0, 0, 1, 1, 'h0);   step("ack_and_err", 0, 7'b0001100, 1, 3);

        // reset mid-burst with flags set, then a clean transaction
        drive(1, 1, 0, 0, 0, 0, 'h20);  step("pre_rst_a0", 1, 7'b0001100, 1, 3);
        drive(1, 1, 0, 0, 0, 0, 'h21);  step("pre_rst_a1", 2, 7'b0001100, 1, 3);
        drive(1, 0, 0, 0, 0, 0, 'h0);
        pulse_reset("rst_mid_burst");
        idle();                         step("post_rst_drop", 0, 7'd0, 0, 0);
        drive(1, 1, 1, 0, 0, 0, 'h30);  step("post_rst_acc", 1, 7'd0, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 'h0);   step("post_rst_ack", 0, 7'd0, 0, 0);
        idle();                         step("post_rst_idle", 0, 7'd0, 0, 0);

        // overflow, abandon, strobe without cycle
        pulse_reset("rst_before_ovf");
        for (int i = 0; i < MO; i++) begin
            drive(1, 1, 0, 0, 0, 0, AW'('h40 + i));
            step("ovf_fill", 3'(i + 1), 7'd0, 0, 0);
        end
        drive(1, 1, 0, 0, 0, 0, 'h44);  step("overflow", 4, 7'b0010000, 1, 4);
        idle();                         step("abandon", 0, 7'b1010000, 1, 4);
        drive(0, 1, 0, 0, 0, 0, 'h50);  step("stb_no_cyc", 0, 7'b1010001, 1, 4);
        idle();                         step("ovf_idle", 0, 7'b1010001, 1, 4);

        // no response for TimeoutCycles cycles
        pulse_reset("rst_before_to");
        drive(1, 1, 0, 0, 0, 0, 'h60);  step("to_acc", 1, 7'd0, 0, 0);
        vv = 7'd0;
        for (int k = 1; k <= TO; k++) begin
            drive(1, 0, 0, 0, 0, 0, 'h0);
            if (k == TO && TimeoutEn) vv = 7'b0100000;
            step("to_wait", 1, vv, vv[5], vv[5] ? 3'd5 : 3'd0);
        end
        drive(1, 0, 0, 0, 1, 0, 'h0);   step("to_ack", 0, vv, vv[5], vv[5] ? 3'd5 : 3'd0);
        idle();                         step("to_idle", 0, vv, vv[5], vv[5] ? 3'd5 : 3'd0);

        // response one cycle short of the limit raises nothing
        pulse_reset("rst_before_to2");
        drive(1, 1, 0, 0, 0, 0, 'h70);  step("to2_acc", 1, 7'd0, 0, 0);
        for (int k = 1; k < TO - 1; k++) begin
            drive(1, 0, 0, 0, 0, 0, 'h0);
            step("to2_wait", 1, 7'd0, 0, 0);
        end
        drive(1, 0, 0, 0, 1, 0, 'h0);   step("to2_ack", 0, 7'd0, 0, 0);
        idle();                         step("to2_idle", 0, 7'd0, 0, 0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_pipe_monitor.md
WB_PIPE_MONITOR -- requirements
Module: wb_pipe_monitor

Interface
REQ-001 DataWidth, default 32, data bus width; multiple of 8.
REQ-002 AddrWidth, default 30, word-address width.
REQ-003 MaxOutstanding, default 4, max accepted-but-unanswered requests, >=1.
REQ-004 TimeoutCycles, default 16, max cycles without a response while requests are outstanding, >=2.
REQ-005 SelWidth localparam = DataWidth/8; CntWidth localparam = $clog2(MaxOutstanding+1).
REQ-006 clk_i  in  1  sole clock; all state on rising edge.
REQ-007 reset_i  in  1  asynchronous, active-high reset.
REQ-008 wb_cyc_o, wb_stb_o, wb_we_o  in  1 each  observed master controls.
REQ-009 wb_addr_o  in  AddrWidth; wb_data_o  in  DataWidth; wb_sel_o  in  SelWidth  observed request payload.
REQ-010 wb_ack_i, wb_err_i, wb_stall_i  in  1 each; wb_data_i  in  DataWidth  observed slave response (data unused).
REQ-011 outstanding_o  out  CntWidth  current outstanding-request count.
REQ-012 violation_o  out  7  sticky per-rule flags, bit map in REQ-017.
REQ-013 error_o  out  1  OR of violation_o.
REQ-014 first_code_o  out  3; first_valid_o  out  1  index of the first-detected violation.

Function
REQ-015 Accept = cyc&stb&!stall; response = ack|err.
REQ-016 Outstanding next-state: cyc=0 -> 0; else +1 on accept, -1 on response, unchanged on both/neither; saturates at 0 and MaxOutstanding.
REQ-017 Violation bits, evaluated combinationally each cycle: 0 STB_NO_CYC stb&!cyc; 1 SPURIOUS response while outstanding==0 or cyc=0; 2 ACK_AND_ERR ack&err; 3 STALL_UNSTABLE previous cycle cyc&stb&stall and current cyc&stb with any of addr/we/sel/data(when we) changed, or stb dropped; 4 OVERFLOW accept while outstanding==MaxOutstanding without response in the same cycle; 5 TIMEOUT; 6 ABANDON cyc falls (1->0) with outstanding>0.
REQ-018 Flags latch one cycle after the offending cycle and stay set until reset.
REQ-019 first_valid_o sets on the first cycle any flag latches; first_code_o = lowest-index bit detected that cycle; both frozen thereafter.
REQ-020 STALL_UNSTABLE uses a registered copy of the request payload and a "stalled" bit captured every cycle.
REQ-021 Monitor is passive: never influences bus signals; all outputs registered.

Reset
REQ-022 reset_i asserted: outstanding_o=0, violation_o=0, error_o=0, first_valid_o=0, first_code_o=0, timeout counter=0, stalled bit=0, payload copy=0.
REQ-023 Reset asserted mid-transaction discards all tracking; first post-reset cycle is treated as previous cyc=0 (no ABANDON, no STALL_UNSTABLE).

Configuration
REQ-024 Macro WB_MONITOR_TIMEOUT_EN defined: counter increments each cycle with outstanding>0 and no response, clears on response or outstanding==0; TIMEOUT raised when counter reaches TimeoutCycles.
REQ-025 Macro undefined: no counter logic; violation_o[5] tied 0.

Structure
REQ-026 Package wb_pkg holds the violation-index enum (3 bits, seven named values) and the 7-bit violation vector typedef.
REQ-027 One sub-module wb_timeout_counter (counter + compare), instantiated only under WB_MONITOR_TIMEOUT_EN.

Verification
REQ-028 Clean burst: 3 accepts back-to-back, acks 2 cycles later each -> outstanding 1,2,3,2,1,0; violation_o=0.
REQ-029 ack with outstanding==0 -> violation_o=7'b0000010 next cycle, first_code_o=1, first_valid_o=1; stays after further clean traffic.
REQ-030 Stalled request, addr 0x10 then 0x14 while stb held -> bit 3 set; simultaneous ack&err later -> bit 2 added, first_code_o still 3.
REQ-031 MaxOutstanding=4: 5th accept without response -> bit 4; then cyc dropped with 4 outstanding -> bit 6, outstanding_o 0 next cycle.
REQ-032 With WB_MONITOR_TIMEOUT_EN, TimeoutCycles=16: one accept, no ack for 16 cycles -> bit 5 set; ack at cycle 15 -> no flag; without macro, bit 5 never set.
REQ-033 reset_i pulsed mid-burst with flags set -> all outputs 0 immediately (asynchronous); next clean transaction raises nothing.
